// File: rtl/shift_req_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : shift_arb_pkg                                          |
// | Description : Shared widths and FSM encoding for shift_req_arbiter.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package shift_arb_pkg;

    localparam int DW_DEF    = 8;
    localparam int SW_DEF    = 8;
    localparam int RW_DEF    = 2 * DW_DEF;
    localparam int EXT_W_DEF = RW_DEF - DW_DEF;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_HOLD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/shift_req_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : shift_req_arbiter_if                                   |
// | Description : Requester-side and result-side handshake bundle.       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface shift_req_arbiter_if
    import shift_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DW_DEF,
    parameter int SW   = SW_DEF,
    parameter int RW   = RW_DEF,
    parameter int IW   = $clog2(NREQ)
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ*SW-1:0] req_shift;
    logic [NREQ-1:0]    req_left;
    logic               res_valid;
    logic               res_ready;
    logic [RW-1:0]      res_data;
    logic [IW-1:0]      res_id;
    logic               busy;

    modport master (
        output req_valid, req_data, req_shift, req_left, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_shift, req_left, res_ready,
        output req_ready, res_valid, res_data, res_id, busy
    );

endinterface
`default_nettype wire

// File: rtl/shift_req_arbiter_shift_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shift_core                                             |
// | Description : Registered zero-fill shifter with load enable.         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module shift_core
    import shift_arb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int SW = SW_DEF,
    parameter int RW = RW_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          load,
    input  wire logic [DW-1:0] data,
    input  wire logic [SW-1:0] shift,
    input  wire logic          left,
    output logic      [RW-1:0] result
);

    logic [RW-1:0] w_ext;
    logic [RW-1:0] w_next;

    assign w_ext = {{(RW-DW){1'b0}}, data};

    // Out-of-range amounts are clamped explicitly so the result never depends on tool shift semantics.
    always_comb begin
        w_next = '0;
        if (left) begin
            if (int'(shift) < RW) w_next = w_ext << shift;
        end else begin
            if (int'(shift) < DW) w_next = w_ext >> shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else if (load) begin
            result <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shift_req_arbiter                                      |
// | Description : Shares one registered shifter between NREQ requesters. |
// |               SHIFT_REQ_ARBITER_RR_EN selects round-robin, otherwise |
// |               fixed lowest-index priority.                           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module shift_req_arbiter
    import shift_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DW_DEF,
    parameter int SW   = SW_DEF,
    parameter int RW   = RW_DEF
) (
    input wire logic          clk,
    input wire logic          rst,
    shift_req_arbiter_if.slave bus
);

    localparam int IW = $clog2(NREQ);

    state_t          r_state;
    logic [IW-1:0]   r_id;
    logic [IW-1:0]   w_grant;
    logic            w_found;
    logic            w_allow;
    logic            w_accept;
    logic [NREQ-1:0] w_ready;

`ifdef SHIFT_REQ_ARBITER_RR_EN
    logic [IW-1:0] r_ptr;

    always_comb begin
        int idx;
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_found && bus.req_valid[idx]) begin
                w_found = 1'b1;
                w_grant = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_grant == IW'(NREQ-1)) ? '0 : w_grant + 1'b1;
        end
    end
`else
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                w_found = 1'b1;
                w_grant = IW'(k);
            end
        end
    end
`endif

    // A held result may be replaced in the same cycle it is consumed.
    assign w_allow  = (r_state == ST_IDLE) || bus.res_ready;
    assign w_accept = w_allow && w_found;

    always_comb begin
        w_ready = '0;
        if (w_accept) w_ready[w_grant] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) r_state <= ST_HOLD;
                ST_HOLD: if (w_allow)  r_state <= w_accept ? ST_HOLD : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_accept) r_id <= w_grant;
        end
    end

    shift_core #(
        .DW (DW),
        .SW (SW),
        .RW (RW)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (w_accept),
        .data   (bus.req_data[w_grant*DW +: DW]),
        .shift  (bus.req_shift[w_grant*SW +: SW]),
        .left   (bus.req_left[w_grant]),
        .result (bus.res_data)
    );

    assign bus.req_ready = w_ready;
    assign bus.res_valid = (r_state == ST_HOLD);
    assign bus.busy      = (r_state == ST_HOLD);
    assign bus.res_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_shift_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_shift_req_arbiter                                   |
// | Description : Self-checking bench for shift_req_arbiter; honours     |
// |               SHIFT_REQ_ARBITER_RR_EN.                               |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_shift_req_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int SW   = 8;
    localparam int RW   = 16;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    bit            m_valid;
    logic [RW-1:0] m_data;
    int            m_id;
    int            m_ptr;

    typedef struct {
        int            req;
        logic [DW-1:0] data;
        logic [SW-1:0] shift;
        bit            left;
        logic [RW-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    shift_req_arbiter_if #(.NREQ(NREQ), .DW(DW), .SW(SW), .RW(RW)) bus ();

    shift_req_arbiter #(.NREQ(NREQ), .DW(DW), .SW(SW), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] ref_shift(int data, int sh, bit left);
        longint v;
        if (left) begin
            if (sh >= RW) return '0;
            v = longint'(data) * (longint'(1) << sh);
            return RW'(v % (longint'(1) << RW));
        end
        if (sh >= DW) return '0;
        return RW'(data / (1 << sh));
    endfunction

    function automatic int ref_grant();
        int start;
`ifdef SHIFT_REQ_ARBITER_RR_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < NREQ; k++)
            if (bus.req_valid[(start + k) % NREQ]) return (start + k) % NREQ;
        return -1;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare the combinational grant, advance the model, compare registered outputs.
    task automatic cycle();
        bit              allow;
        int              g;
        logic [NREQ-1:0] exp_ready;
        #1;
        allow     = !m_valid || bus.res_ready;
        g         = allow ? ref_grant() : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", bus.req_ready, exp_ready);
        if (allow) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = ref_shift(int'(bus.req_data[g*DW +: DW]), int'(bus.req_shift[g*SW +: SW]), bus.req_left[g]);
                m_id    = g;
                m_ptr   = (g + 1) % NREQ;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("res_valid", bus.res_valid, m_valid);
        check("busy", bus.busy, m_valid);
        if (m_valid) begin
            check("res_data", bus.res_data, m_data);
            check("res_id", bus.res_id, m_id);
        end
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_shift = '0;
        bus.req_left  = '0;
    endtask

    task automatic set_req(int i, logic [DW-1:0] d, logic [SW-1:0] s, bit l);
        bus.req_valid[i]         = 1'b1;
        bus.req_data[i*DW +: DW] = d;
        bus.req_shift[i*SW +: SW] = s;
        bus.req_left[i]          = l;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        m_valid = 1'b0;
        m_ptr   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_id;
        rst           = 1'b1;
        bus.res_ready = 1'b0;
        clear_reqs();
        do_reset();

        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_id", bus.res_id, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_req_ready", bus.req_ready, 0);

        vecs[0] = '{1, 8'h81, 8'd4,  1'b1, 16'h0810};
        vecs[1] = '{2, 8'hF0, 8'd3,  1'b0, 16'h001E};
        vecs[2] = '{3, 8'hF0, 8'd9,  1'b0, 16'h0000};
        vecs[3] = '{0, 8'h81, 8'd16, 1'b1, 16'h0000};
        vecs[4] = '{1, 8'hFF, 8'd15, 1'b1, 16'h8000};
        vecs[5] = '{2, 8'hFF, 8'd8,  1'b1, 16'hFF00};
        vecs[6] = '{3, 8'h80, 8'd7,  1'b0, 16'h0001};
        vecs[7] = '{0, 8'hFF, 8'd8,  1'b0, 16'h0000};
        vecs[8] = '{1, 8'h01, 8'd0,  1'b0, 16'h0001};
        vecs[9] = '{2, 8'hC3, 8'd12, 1'b1, 16'h3000};

        bus.res_ready = 1'b1;
        foreach (vecs[i]) begin
            clear_reqs();
            set_req(vecs[i].req, vecs[i].data, vecs[i].shift, vecs[i].left);
            cycle();
            check("vec_data", bus.res_data, vecs[i].exp);
            check("vec_id", bus.res_id, vecs[i].req);
        end
        clear_reqs();
        cycle();

        // Saturated requesters with a free consumer.
        do_reset();
        bus.res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, DW'(i + 1), SW'(i), 1'b1);
        for (int n = 0; n < 5; n++) begin
            cycle();
`ifdef SHIFT_REQ_ARBITER_RR_EN
            exp_id = n % NREQ;
`else
            exp_id = 0;
`endif
            check("stream_id", bus.res_id, exp_id);
        end

        // Backpressure on a held 0x00FF result.
        do_reset();
        bus.res_ready = 1'b1;
        set_req(1, 8'hFF, 8'd0, 1'b1);
        cycle();
        check("bp_first_id", bus.res_id, 1);
        bus.res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h11, 8'd1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            cycle();
            check("bp_data", bus.res_data, 16'h00FF);
            check("bp_id", bus.res_id, 1);
            check("bp_ready", bus.req_ready, 0);
        end
        bus.res_ready = 1'b1;
        cycle();
`ifdef SHIFT_REQ_ARBITER_RR_EN
        exp_id = 2;
`else
        exp_id = 0;
`endif
        check("bp_next_id", bus.res_id, exp_id);

        // Asynchronous reset while holding a result.
        bus.res_ready = 1'b0;
        clear_reqs();
        #2;
        rst = 1'b1;
        #1;
        check("arst_res_valid", bus.res_valid, 0);
        check("arst_busy", bus.busy, 0);
        m_valid = 1'b0;
        m_ptr   = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        cycle();
        check("arst_no_stale", bus.res_valid, 0);
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h05, 8'd2, 1'b1);
        cycle();
        check("arst_first_id", bus.res_id, 0);

        // Requesters 0 and 2 contending.
        do_reset();
        bus.res_ready = 1'b1;
        set_req(0, 8'h0F, 8'd1, 1'b1);
        set_req(2, 8'hF0, 8'd1, 1'b0);
        for (int n = 0; n < 6; n++) begin
            cycle();
`ifdef SHIFT_REQ_ARBITER_RR_EN
            exp_id = (n % 2 == 0) ? 0 : 2;
`else
            exp_id = 0;
`endif
            check("pri_id", bus.res_id, exp_id);
        end

        // Randomised traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                bus.req_data[i*DW +: DW]  = DW'($urandom);
                bus.req_shift[i*SW +: SW] = SW'($urandom_range(0, 20));
                bus.req_left[i]           = 1'($urandom);
            end
            bus.res_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
